// File: rtl/mem_pkg.sv
// Shared encodings for the load/store sequencer.
// Size codes, FSM states and the default data region.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [11:0] REGION_DEF = 12'h001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_READ0,
    S_READ1,
    S_WRITE0,
    S_WRITE1,
    S_DONE
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Two-phase 32-bit data bus between the sequencer and memory.
// Master drives the command, slave returns read data.
interface mem_ctrl_if;

  logic        bus_en;
  logic        bus_rw;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_en,
    output bus_rw,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_en,
    input  bus_rw,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/mem_lane.sv
// Byte-lane steering: load extraction and store merge.
// Purely combinational, little-endian lanes.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    unique case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = word;
    unique case (1'b1)
      (size == SZ_BYTE):
        load_val = {{24{sext & b[7]}}, b};
      (size == SZ_HALF):
        load_val = {{16{sext & h[15]}}, h};
      default:
        load_val = word;
    endcase
  end

  always_comb begin
    store_word = word;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        unique case (off)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      (size == SZ_HALF): begin
        if (off[1]) store_word[31:16] = wdata[15:0];
        else        store_word[15:0]  = wdata[15:0];
      end
      default:
        store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store sequencer from the CPU memory stage to the
// two-phase bus; sub-word stores are read-modify-write.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter logic [11:0] REGION = REGION_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  mem_ctrl_if.master  bus
);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        illegal;
  logic        in_wst;
  logic        q_wst;
  logic [31:0] load_val;
  logic [31:0] store_word;

  mem_lane u_lane (
    .size       (size_q),
    .sext       (sext_q),
    .off        (addr_q[1:0]),
    .word       (bus.bus_rdata),
    .wdata      (wr_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    illegal = (size == 2'd3)
            | ((size == SZ_HALF) & addr[0])
            | ((size == SZ_WORD) & (|addr[1:0]))
            | (addr[31:20] != REGION);
    in_wst  = we & (size == SZ_WORD);
    q_wst   = we_q & (size_q == SZ_WORD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d   = we;
          size_d = size;
          sext_d = sext;
          addr_d = addr;
          wr_d   = wdata;
          err_d  = illegal;
          // Bus cycles must start on a low-half (phase 0) cycle
          if (illegal)      state_d = S_DONE;
          else if (!phase_q) state_d = S_ALIGN;
          else if (in_wst)   state_d = S_WRITE0;
          else               state_d = S_READ0;
        end
      end
      S_ALIGN:  state_d = q_wst ? S_WRITE0 : S_READ0;
      S_READ0:  state_d = S_READ1;
      S_READ1: begin
        if (we_q) begin
          wr_d    = store_word;
          state_d = S_WRITE0;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WRITE0: state_d = S_WRITE1;
      S_WRITE1: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata         = rdata_q;
    ready         = (state_q == S_DONE);
    err           = (state_q == S_DONE) & err_q;
    bus.bus_en    = (state_q == S_READ0)
                  | (state_q == S_READ1)
                  | (state_q == S_WRITE0)
                  | (state_q == S_WRITE1);
    bus.bus_rw    = (state_q == S_WRITE0)
                  | (state_q == S_WRITE1);
    bus.bus_addr  = {addr_q[31:2], 2'b00};
    bus.bus_wdata = wr_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: loads, RMW stores, errors,
// phase alignment and mid-transaction reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] mem_word = '0;
  logic        ph = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl_if bif ();
  assign bif.bus_rdata = mem_word;

  mem_ctrl #(.REGION(12'h001)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .size  (size),
    .sext  (sext),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  // Reference bus phase: 0 in reset, toggles every cycle
  always @(posedge clk) ph <= rst ? 1'b0 : ~ph;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic        a_sext,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        a_ph,
    output int          lat,
    output int          en_cnt,
    output int          rw_cnt,
    output logic [31:0] seen_addr,
    output logic [31:0] seen_wdata,
    output logic        seen_err
  );
    lat = 0; en_cnt = 0; rw_cnt = 0;
    seen_addr = '0; seen_wdata = '0; seen_err = 1'b0;
    @(negedge clk);
    if (ph != a_ph) @(negedge clk);
    req = 1'b1; we = a_we; size = a_size;
    sext = a_sext; addr = a_addr; wdata = a_wdata;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bif.bus_en) begin
        en_cnt++;
        seen_addr = bif.bus_addr;
      end
      if (bif.bus_rw) begin
        rw_cnt++;
        seen_wdata = bif.bus_wdata;
      end
      if (k == 1) begin
        req = 1'b0; we = $urandom_range(1);
        size = 2'($urandom_range(3));
        sext = $urandom_range(1);
        addr = $urandom; wdata = $urandom;
      end
      if (ready) begin
        lat = k;
        seen_err = err;
        break;
      end
    end
  endtask

  int          lat, en_c, rw_c;
  logic [31:0] s_addr, s_wd;
  logic        s_err;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_en", 32'(bif.bus_en), 32'h0);
    chk("rst_rw", 32'(bif.bus_rw), 32'h0);
    chk("rst_addr", bif.bus_addr, 32'h0);
    chk("rst_wdata", bif.bus_wdata, 32'h0);
    rst = 1'b0;

    // Word load, no alignment wait
    mem_word = 32'hDEADBEEF;
    access(1'b0, 2'd2, 1'b0, 32'h0010_0008, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("wl_lat", 32'(lat), 32'd3);
    chk("wl_en", 32'(en_c), 32'd2);
    chk("wl_rw", 32'(rw_c), 32'd0);
    chk("wl_addr", s_addr, 32'h0010_0008);
    chk("wl_err", 32'(s_err), 32'h0);
    chk("wl_rdata", rdata, 32'hDEADBEEF);

    // Signed byte load needing an align cycle
    mem_word = 32'h80123456;
    access(1'b0, 2'd0, 1'b1, 32'h0010_0003, 32'h0,
           1'b0, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("bl_lat", 32'(lat), 32'd4);
    chk("bl_en", 32'(en_c), 32'd2);
    chk("bl_addr", s_addr, 32'h0010_0000);
    chk("bl_rdata", rdata, 32'hFFFFFF80);

    access(1'b0, 2'd0, 1'b0, 32'h0010_0001, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("bz_lat", 32'(lat), 32'd3);
    chk("bz_rdata", rdata, 32'h0000_0034);

    access(1'b0, 2'd1, 1'b1, 32'h0010_0002, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("hs_rdata", rdata, 32'hFFFF8012);

    access(1'b0, 2'd1, 1'b1, 32'h0010_0000, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("hl_rdata", rdata, 32'h0000_3456);

    // Halfword RMW store
    mem_word = 32'h11223344;
    access(1'b1, 2'd1, 1'b0, 32'h0010_0002, 32'h0000ABCD,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("hw_lat", 32'(lat), 32'd5);
    chk("hw_en", 32'(en_c), 32'd4);
    chk("hw_rw", 32'(rw_c), 32'd2);
    chk("hw_wdata", s_wd, 32'hABCD3344);
    chk("hw_rdata", rdata, 32'h0000_3456);

    // Byte RMW store with align
    access(1'b1, 2'd0, 1'b0, 32'h0010_0001, 32'h000000EE,
           1'b0, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("bw_lat", 32'(lat), 32'd6);
    chk("bw_rw", 32'(rw_c), 32'd2);
    chk("bw_wdata", s_wd, 32'h1122EE44);

    // Word store
    access(1'b1, 2'd2, 1'b0, 32'h0010_0010, 32'hCAFEF00D,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("ws_lat", 32'(lat), 32'd3);
    chk("ws_en", 32'(en_c), 32'd2);
    chk("ws_rw", 32'(rw_c), 32'd2);
    chk("ws_wdata", s_wd, 32'hCAFEF00D);
    chk("ws_addr", s_addr, 32'h0010_0010);
    chk("ws_rdata", rdata, 32'h0000_3456);

    access(1'b1, 2'd2, 1'b0, 32'h0010_0020, 32'h12345678,
           1'b0, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("wsa_lat", 32'(lat), 32'd4);
    chk("wsa_wdata", s_wd, 32'h12345678);

    // Illegal accesses
    access(1'b0, 2'd2, 1'b0, 32'h0010_0002, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("e1_lat", 32'(lat), 32'd1);
    chk("e1_err", 32'(s_err), 32'h1);
    chk("e1_en", 32'(en_c), 32'd0);
    access(1'b1, 2'd1, 1'b0, 32'h0010_0001, 32'h0,
           1'b0, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("e2_lat", 32'(lat), 32'd1);
    chk("e2_err", 32'(s_err), 32'h1);
    chk("e2_en", 32'(en_c), 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h0020_0000, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("e3_lat", 32'(lat), 32'd1);
    chk("e3_err", 32'(s_err), 32'h1);
    chk("e3_en", 32'(en_c), 32'd0);
    access(1'b0, 2'd3, 1'b0, 32'h0010_0000, 32'h0,
           1'b0, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("e4_err", 32'(s_err), 32'h1);
    chk("e4_rdata", rdata, 32'h0000_3456);

    // Reset during READ1 of a word load
    mem_word = 32'h55AA55AA;
    @(negedge clk);
    if (ph != 1'b1) @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2;
    sext = 1'b0; addr = 32'h0010_0004;
    @(negedge clk);
    req = 1'b0;
    chk("rr_read0", 32'(bif.bus_en), 32'h1);
    @(negedge clk);
    chk("rr_read1", 32'(bif.bus_en), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_ready", 32'(ready), 32'h0);
    chk("rr_en", 32'(bif.bus_en), 32'h0);
    chk("rr_rdata", rdata, 32'h0);
    chk("rr_addr", bif.bus_addr, 32'h0);

    mem_word = 32'h0BADF00D;
    access(1'b0, 2'd2, 1'b0, 32'h0010_000C, 32'h0,
           1'b1, lat, en_c, rw_c, s_addr, s_wd, s_err);
    chk("ra_lat", 32'(lat), 32'd3);
    chk("ra_rdata", rdata, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
